inst_fetch_master: RTL and testbench

- Instruction-fetch initiator that drives the synchronous-read instruction RAM port: word address in, data registered one cycle later.
- Owns the fetch PC and issues sequential word reads.
- Captures returned words into a 2-entry output queue and presents {pc, inst} to decode over a valid/ready handshake.
- Handles redirects (branch/exception) by flushing in-flight and queued fetches.

---
 rtl/inst_fetch_master_if.sv | 42 ++++
 rtl/inst_fetch_master.sv | 102 ++++++++++
 tb/tb_inst_fetch_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_master_if.sv
// Bundle between the instruction-fetch master and its environment:
// the synchronous-read RAM port, the redirect request and the decode handshake.
interface inst_fetch_master_if #(
    parameter int AW = 16
);
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_d;
    logic [31:0]   ram_spo;

    logic          redirect_valid;
    logic [31:0]   redirect_pc;

    // out_valid/out_ready: a transfer happens on a rising edge where both are 1;
    // while out_valid=1 and out_ready=0 the payload stays stable, and out_valid
    // never depends combinationally on out_ready.
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_ready;

    logic [1:0]    dbg_occ;
    logic          dbg_inflight;

    modport master (
        output ram_we, ram_a, ram_d,
        input  ram_spo,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_inst,
        input  out_ready,
        output dbg_occ, dbg_inflight
    );

    modport slave (
        input  ram_we, ram_a, ram_d,
        output ram_spo,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_inst,
        output out_ready,
        input  dbg_occ, dbg_inflight
    );
endinterface

// File: rtl/inst_fetch_master.sv
// Sequential instruction fetcher: one word read per cycle from a synchronous RAM,
// results buffered in a 2-entry queue, flushed and restarted on redirect.
module inst_fetch_master #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          AW       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    inst_fetch_master_if.master        bus
);
    logic [31:0] r_fetch_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight;
    logic [1:0]  r_occ;
    logic [31:0] r_q0_pc;
    logic [31:0] r_q0_inst;
    logic [31:0] r_q1_pc;
    logic [31:0] r_q1_inst;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_used;
    logic [31:0] w_redirect_pc;

    // Credit check counts the in-flight word as occupied, so a push always fits.
    assign w_pop         = (r_occ != 2'd0) && bus.out_ready;
    assign w_used        = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue       = !bus.redirect_valid && (w_used < 3'd2);
    assign w_push        = r_inflight && !bus.redirect_valid;
    assign w_redirect_pc = bus.redirect_pc & 32'hffff_fffc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Entry 0 is always the head; entry 1 shifts down on a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ     <= 2'd0;
            r_q0_pc   <= 32'd0;
            r_q0_inst <= 32'd0;
            r_q1_pc   <= 32'd0;
            r_q1_inst <= 32'd0;
        end else if (bus.redirect_valid) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_q0_pc   <= r_inflight_pc;
                        r_q0_inst <= bus.ram_spo;
                    end else begin
                        r_q1_pc   <= r_inflight_pc;
                        r_q1_inst <= bus.ram_spo;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_q0_pc   <= r_q1_pc;
                    r_q0_inst <= r_q1_inst;
                    r_occ     <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_q0_pc   <= r_inflight_pc;
                        r_q0_inst <= bus.ram_spo;
                    end else begin
                        r_q0_pc   <= r_q1_pc;
                        r_q0_inst <= r_q1_inst;
                        r_q1_pc   <= r_inflight_pc;
                        r_q1_inst <= bus.ram_spo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ram_we       = 1'b0;
    assign bus.ram_d        = 32'd0;
    assign bus.ram_a        = r_fetch_pc[AW+1:2];
    assign bus.out_valid    = (r_occ != 2'd0);
    assign bus.out_pc       = r_q0_pc;
    assign bus.out_inst     = r_q0_inst;
    assign bus.dbg_occ      = r_occ;
    assign bus.dbg_inflight = r_inflight;
endmodule

// File: tb/tb_inst_fetch_master.sv
// Bench for inst_fetch_master: directed scenarios plus a randomized run scored
// against a program-order model (next expected PC, word derived from the address).
module tb_inst_fetch_master;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          AW       = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    inst_fetch_master_if #(.AW(AW)) u_if();

    inst_fetch_master #(.RESET_PC(RESET_PC), .AW(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    // RAM contents: word at address a is 0xA0 + a.
    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return 32'hA0 + {16'h0, a};
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return word_of(pc[AW+1:2]);
    endfunction

    always @(posedge clk) u_if.ram_spo <= word_of(u_if.ram_a);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset();
        u_if.out_ready      = 1'b0;
        u_if.redirect_valid = 1'b0;
        u_if.redirect_pc    = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rp;
        rp = RESET_PC;
        u_if.out_ready      = 1'b0;
        u_if.redirect_valid = 1'b0;
        u_if.redirect_pc    = 32'd0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", u_if.out_valid); else n_pass++;
        n_checks++; if (u_if.out_pc !== 32'd0) $display("FAIL reset_pc: got %h want 0", u_if.out_pc); else n_pass++;
        n_checks++; if (u_if.out_inst !== 32'd0) $display("FAIL reset_inst: got %h want 0", u_if.out_inst); else n_pass++;
        n_checks++; if (u_if.ram_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", u_if.ram_we); else n_pass++;
        n_checks++; if (u_if.ram_d !== 32'd0) $display("FAIL reset_d: got %h want 0", u_if.ram_d); else n_pass++;
        n_checks++; if (u_if.ram_a !== rp[AW+1:2]) $display("FAIL reset_ram_a: got %h want %h", u_if.ram_a, rp[AW+1:2]); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        u_if.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL stream_latency: got valid %0b want 0 one cycle after reset", u_if.out_valid); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_pc !== RESET_PC + 4 * i || u_if.out_inst !== 32'hA0 + i)
                $display("FAIL stream_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, u_if.out_valid, u_if.out_pc, u_if.out_inst, RESET_PC + 4 * i, 32'hA0 + i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 10 && u_if.out_valid !== 1'b1; k++) @(negedge clk);
        n_checks++; if (u_if.out_valid !== 1'b1) $display("FAIL bp_wait_valid: got %0b want 1", u_if.out_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_pc !== RESET_PC || u_if.out_inst !== 32'hA0)
                $display("FAIL bp_hold_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=a0",
                         i, u_if.out_valid, u_if.out_pc, u_if.out_inst, RESET_PC);
            else n_pass++;
            n_checks++; if (u_if.ram_a !== 16'd2) $display("FAIL bp_ram_a_%0d: got %h want 0002", i, u_if.ram_a); else n_pass++;
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(RESET_PC + 4 * i);
        u_if.out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_pc !== e || u_if.out_inst !== inst_of(e))
                $display("FAIL bp_release: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         u_if.out_valid, u_if.out_pc, u_if.out_inst, e, inst_of(e));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        u_if.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h1c000043;
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== RESET_PC + 32'd12)
            $display("FAIL redir_last_old: got v=%0b pc=%h want v=1 pc=%h", u_if.out_valid, u_if.out_pc, RESET_PC + 32'd12);
        else n_pass++;
        @(negedge clk);
        u_if.redirect_valid = 1'b0;
        n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL redir_gap1: got %0b want 0", u_if.out_valid); else n_pass++;
        n_checks++; if (u_if.ram_a !== 16'd16) $display("FAIL redir_ram_a: got %h want 0010", u_if.ram_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL redir_gap2: got %0b want 0", u_if.out_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'h1c000040 + 4 * i || u_if.out_inst !== word_of(16'd16 + 16'(i)))
                $display("FAIL redir_new_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h", i, u_if.out_valid,
                         u_if.out_pc, u_if.out_inst, 32'h1c000040 + 4 * i, word_of(16'd16 + 16'(i)));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int k = 0; k < 10 && ({1'b0, u_if.dbg_occ} + {2'b00, u_if.dbg_inflight}) != 3'd2; k++) @(negedge clk);
        n_checks++;
        if (({1'b0, u_if.dbg_occ} + {2'b00, u_if.dbg_inflight}) !== 3'd2)
            $display("FAIL full_wait: got occ=%0d inflight=%0b want total 2", u_if.dbg_occ, u_if.dbg_inflight);
        else n_pass++;
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h1c000100;
        @(negedge clk);
        u_if.redirect_valid = 1'b0;
        u_if.out_ready      = 1'b1;
        n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL full_flush: got %0b want 0", u_if.out_valid); else n_pass++;
        for (int k = 0; k < 8 && u_if.out_valid !== 1'b1; k++) @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'h1c000100 || u_if.out_inst !== word_of(16'd64))
            $display("FAIL full_first: got v=%0b pc=%h inst=%h want v=1 pc=1c000100 inst=%h",
                     u_if.out_valid, u_if.out_pc, u_if.out_inst, word_of(16'd64));
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rp;
        rp = RESET_PC;
        do_reset();
        u_if.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (u_if.out_valid !== 1'b0 || u_if.out_pc !== 32'd0 || u_if.out_inst !== 32'd0 || u_if.ram_a !== rp[AW+1:2])
            $display("FAIL async_reset: got v=%0b pc=%h inst=%h a=%h want v=0 pc=0 inst=0 a=%h",
                     u_if.out_valid, u_if.out_pc, u_if.out_inst, u_if.ram_a, rp[AW+1:2]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== RESET_PC || u_if.out_inst !== 32'hA0)
            $display("FAIL restart: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=a0",
                     u_if.out_valid, u_if.out_pc, u_if.out_inst, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        u_if.out_ready = 1'b1;
        @(negedge clk);
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h1c000200;
        @(negedge clk);
        u_if.redirect_pc    = 32'hffffffff;
        @(negedge clk);
        u_if.redirect_valid = 1'b0;
        for (int k = 0; k < 8 && u_if.out_valid !== 1'b1; k++) @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'hfffffffc || u_if.out_inst !== word_of(16'hffff))
            $display("FAIL wrap_top: got v=%0b pc=%h inst=%h want v=1 pc=fffffffc inst=%h",
                     u_if.out_valid, u_if.out_pc, u_if.out_inst, word_of(16'hffff));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'd0 || u_if.out_inst !== 32'hA0)
            $display("FAIL wrap_zero: got v=%0b pc=%h inst=%h want v=1 pc=0 inst=a0",
                     u_if.out_valid, u_if.out_pc, u_if.out_inst);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;
        logic        prev_stall;
        logic        prev_redir;
        int          pops;
        int          bad;
        do_reset();
        exp_pc     = RESET_PC;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        prev_pc    = 32'd0;
        prev_inst  = 32'd0;
        pops       = 0;
        bad        = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            u_if.out_ready      = ($urandom_range(0, 99) < 70);
            u_if.redirect_valid = ($urandom_range(0, 99) < 3);
            u_if.redirect_pc    = $urandom();
            if (prev_redir) begin
                n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL rnd_flush @%0d: got v=%0b want 0", cyc, u_if.out_valid); else n_pass++;
            end else if (prev_stall) begin
                n_checks++;
                if (u_if.out_valid !== 1'b1 || u_if.out_pc !== prev_pc || u_if.out_inst !== prev_inst)
                    $display("FAIL rnd_hold @%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                             cyc, u_if.out_valid, u_if.out_pc, u_if.out_inst, prev_pc, prev_inst);
                else n_pass++;
            end
            if (u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
                pops++;
                n_checks++;
                if (u_if.out_pc !== exp_pc || u_if.out_inst !== inst_of(exp_pc)) begin
                    $display("FAIL rnd_pop @%0d: got pc=%h inst=%h want pc=%h inst=%h",
                             cyc, u_if.out_pc, u_if.out_inst, exp_pc, inst_of(exp_pc));
                    bad++;
                end else n_pass++;
                exp_pc = exp_pc + 32'd4;
            end
            n_checks++;
            if (({1'b0, u_if.dbg_occ} + {2'b00, u_if.dbg_inflight}) > 3'd2)
                $display("FAIL rnd_credit @%0d: got occ=%0d inflight=%0b want total <= 2", cyc, u_if.dbg_occ, u_if.dbg_inflight);
            else n_pass++;
            if (u_if.redirect_valid) exp_pc = u_if.redirect_pc & 32'hffff_fffc;
            prev_stall = u_if.out_valid & !u_if.out_ready & !u_if.redirect_valid;
            prev_redir = u_if.redirect_valid;
            prev_pc    = u_if.out_pc;
            prev_inst  = u_if.out_inst;
            if (bad > 5) break;
            @(negedge clk);
        end
        u_if.redirect_valid = 1'b0;
        n_checks++; if (pops < 1000) $display("FAIL rnd_throughput: got %0d pops want >= 1000", pops); else n_pass++;
    endtask

    initial begin
        u_if.out_ready      = 1'b0;
        u_if.redirect_valid = 1'b0;
        u_if.redirect_pc    = 32'd0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
